// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter: round-robin arbiter timing intervals on a shared counter; CTR_ARB_ABORT_EN adds abort/aborted
module counter_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 4
) (
   input  logic               clk,
   input  logic               R,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] len,
   output logic [NREQ-1:0]    gnt,
   output logic               done,
   output logic               busy,
   output logic               ctr_rst,
   input  logic [CW-1:0]      ctr_val
`ifdef CTR_ARB_ABORT_EN
   ,
   input  logic               abort,
   output logic               aborted
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
   state_t r_state, w_next;
   logic [NREQ-1:0] r_gnt;
   logic [CW-1:0] r_len_q, w_len;
   logic [PW-1:0] r_rr_ptr, w_win;
   logic w_any, w_abt, r_abt;
   int w_best;
`ifdef CTR_ARB_ABORT_EN
   assign w_abt   = abort;
   assign aborted = (r_state == DONE) && r_abt;
`else
   assign w_abt = 1'b0;
`endif
   assign gnt     = r_gnt;
   assign busy    = r_state != IDLE;
   assign ctr_rst = r_state != RUN;
   assign done    = (r_state == DONE) && !r_abt;
   // round-robin winner: set request at the smallest distance after r_rr_ptr
   always_comb begin
      w_any  = |req;
      w_win  = r_rr_ptr;
      w_len  = '0;
      w_best = NREQ;
      for (int j = 0; j < NREQ; j++)
         if (req[j] && ((j + NREQ - 1 - int'(r_rr_ptr)) % NREQ) < w_best) begin
            w_best = (j + NREQ - 1 - int'(r_rr_ptr)) % NREQ;
            w_win  = PW'(j);
            w_len  = len[j*CW +: CW];
         end
   end
   // next state; an abort in RUN takes precedence over the length compare
   always_comb begin
      w_next = (r_state == IDLE)  ? (w_any ? CLEAR : IDLE) :
               (r_state == CLEAR) ? RUN :
               (r_state == RUN)   ? ((w_abt || ctr_val >= r_len_q) ? DONE : RUN) :
                                    IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      r_state <= R ? IDLE : w_next;
   end
   // grant, latched length, rotation pointer and abort marker
   always_ff @(posedge clk) begin
      if (R) begin
         r_gnt    <= '0;
         r_len_q  <= '0;
         r_rr_ptr <= PW'(NREQ - 1);
         r_abt    <= 1'b0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_gnt    <= NREQ'(1) << w_win;
            r_len_q  <= w_len;
            r_rr_ptr <= w_win;
         end else if (r_state == DONE)
            r_gnt <= '0;
         r_abt <= (r_state == RUN) && w_abt;
      end
   end
endmodule
